// File: rtl/mul_iterative_unit.sv
// Iterative shift-add RV64M multiply unit.
// The operands are converted to magnitudes when a request is accepted. Each
// CALC cycle then retires BITS_PER_CYCLE multiplier bits into a double-width
// accumulator. When the unit enters DONE, the product is conditionally negated
// and the requested half is selected. For MULW the low word is sign-extended
// instead.
// XLEN must be even, at least 32, and a multiple of BITS_PER_CYCLE (1, 2 or 4).
module mul_iterative_unit #(
    parameter int XLEN           = 64,
    parameter int BITS_PER_CYCLE = 2,
    parameter bit OPW_EN         = 1'b1
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Flush,
    input  logic            InValid,
    output logic            InReady,
    input  logic [XLEN-1:0] MultiplicandIn,
    input  logic [XLEN-1:0] MultiplierIn,
    input  logic [6:0]      OpCodeIn,
    input  logic [2:0]      Funct3In,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [XLEN-1:0] ResultOut
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP32   = 7'b0111011;
    localparam int         PW         = 2 * XLEN;
    localparam int         STEPS_FULL = XLEN / BITS_PER_CYCLE;
    localparam int         STEPS_W    = 32 / BITS_PER_CYCLE;
    localparam int         CNT_W      = $clog2(STEPS_FULL + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_MUL,
        OP_MULH,
        OP_MULHSU,
        OP_MULHU,
        OP_MULW,
        OP_BAD
    } op_e;

    state_e          state_q;
    op_e             op_q;
    logic            neg_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [XLEN-1:0] result_q;

    op_e             op_d;
    logic            sign_a;
    logic            sign_b;
    logic            neg_d;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [CNT_W-1:0] cnt_init;

    logic [PW-1:0]   partial;
    logic [PW-1:0]   acc_d;
    logic [PW-1:0]   mcand_d;
    logic [XLEN-1:0] mplier_d;
    logic [CNT_W-1:0] cnt_d;
    logic [PW-1:0]   prod;
    logic [XLEN-1:0] result_d;

    assign InReady   = in_ready_q;
    assign OutValid  = out_valid_q;
    assign ResultOut = result_q;

    // Decode the incoming request and reduce signed operands to magnitudes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        op_d = OP_BAD;
        if (OpCodeIn == OPC_OP) begin
            case (Funct3In)
                3'b000:  op_d = OP_MUL;
                3'b001:  op_d = OP_MULH;
                3'b010:  op_d = OP_MULHSU;
                3'b011:  op_d = OP_MULHU;
                default: op_d = OP_BAD;
            endcase
        end else if (OPW_EN && OpCodeIn == OPC_OP32 && Funct3In == 3'b000) begin
            op_d = OP_MULW;
        end

        // The low product bits do not depend on signedness, so only the high-half ops sign-adjust.
        sign_a = (op_d == OP_MULH || op_d == OP_MULHSU) && MultiplicandIn[XLEN-1];
        sign_b = (op_d == OP_MULH) && MultiplierIn[XLEN-1];
        // The negation of -2^(XLEN-1) is the same bit pattern, which is correct read as unsigned 2^(XLEN-1).
        mag_a  = sign_a ? -MultiplicandIn : MultiplicandIn;
        mag_b  = sign_b ? -MultiplierIn : MultiplierIn;
        neg_d  = sign_a ^ sign_b;

        cnt_init = (op_d == OP_MULW) ? CNT_W'(STEPS_W) : CNT_W'(STEPS_FULL);
    end

    // Compute one shift-add step and the post-processed result from its outcome.
    always_comb begin
        partial = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (mplier_q[j]) begin
                partial = partial + (mcand_q << j);
            end
        end
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q - CNT_W'(1);

        prod = neg_q ? -acc_d : acc_d;
        case (op_q)
            OP_MUL:                       result_d = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod[PW-1:XLEN];
            OP_MULW:                      result_d = {{(XLEN-32){prod[31]}}, prod[31:0]};
            default:                      result_d = '0;
        endcase
    end

    // Control FSM. It owns all state, the datapath registers and the registered handshake outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (Rst) begin
            // NOTE: the datapath registers are reset too, so that no X or stale value survives an abort.
            state_q     <= ST_IDLE;
            op_q        <= OP_MUL;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (Flush) begin
            // Abort without touching ResultOut. A DONE result is dropped even if OutReady is high.
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (InValid) begin
                        op_q       <= op_d;
                        neg_q      <= neg_d;
                        cnt_q      <= cnt_init;
                        acc_q      <= '0;
                        mcand_q    <= {{XLEN{1'b0}}, mag_a};
                        mplier_q   <= mag_b;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_d;
                    if (cnt_d == '0) begin
                        result_q    <= result_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (OutReady) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iterative_unit.sv
// Testbench for mul_iterative_unit with a scoreboard.
// The stimulus pushes the expected result and latency of each tracked request.
// An independent monitor pops and compares them when OutValid rises.
module tb_mul_iterative_unit;

    localparam int         XLEN     = 64;
    localparam int         BPC      = 2;
    localparam int         LAT_FULL = XLEN / BPC + 1;
    localparam int         LAT_W    = 32 / BPC + 1;
    localparam logic [6:0] OPC_OP   = 7'b0110011;
    localparam logic [6:0] OPC_W    = 7'b0111011;

    logic            Clk = 1'b0;
    logic            Rst;
    logic            Flush;
    logic            InValid;
    logic            InReady;
    logic [XLEN-1:0] MultiplicandIn;
    logic [XLEN-1:0] MultiplierIn;
    logic [6:0]      OpCodeIn;
    logic [2:0]      Funct3In;
    logic            OutValid;
    logic            OutReady;
    logic [XLEN-1:0] ResultOut;

    typedef struct {
        logic [XLEN-1:0] res;
        int              acc;
        int              lat;
    } exp_t;

    typedef struct {
        logic [6:0]      opc;
        logic [2:0]      f3;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } req_t;

    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    int              cyc    = 0;
    bit              seen   = 1'b0;
    logic [XLEN-1:0] held;

    mul_iterative_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC), .OPW_EN(1'b1)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Flush         (Flush),
        .InValid       (InValid),
        .InReady       (InReady),
        .MultiplicandIn(MultiplicandIn),
        .MultiplierIn  (MultiplierIn),
        .OpCodeIn      (OpCodeIn),
        .Funct3In      (Funct3In),
        .OutValid      (OutValid),
        .OutReady      (OutReady),
        .ResultOut     (ResultOut)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
    endtask

    // Reference model: full-width products of sign- or zero-extended operands, taken mod 2^128.
    function automatic logic [XLEN-1:0] ref_mul(input logic [6:0] opc, input logic [2:0] f3,
                                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] wa;
        logic [2*XLEN-1:0] wb;
        logic [2*XLEN-1:0] p;
        logic [31:0]       w;
        if (opc == OPC_OP && f3 <= 3'd3) begin
            wa = {{XLEN{(f3 == 3'd1 || f3 == 3'd2) && a[XLEN-1]}}, a};
            wb = {{XLEN{(f3 == 3'd1) && b[XLEN-1]}}, b};
            p  = wa * wb;
            return (f3 == 3'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
        end
        if (opc == OPC_W && f3 == 3'd0) begin
            w = a[31:0] * b[31:0];
            return {{(XLEN-32){w[31]}}, w};
        end
        return '0;
    endfunction

    function automatic int ref_lat(input logic [6:0] opc, input logic [2:0] f3);
        return (opc == OPC_W && f3 == 3'd0) ? LAT_W : LAT_FULL;
    endfunction

    // Called at a negedge. The task waits for InReady and presents a request for one cycle.
    // It records the expectation when track is set.
    task automatic issue(input req_t r, input bit track);
        int n = 0;
        exp_t e;
        while (!InReady && n < 300) begin
            @(negedge Clk);
            n++;
        end
        if (!InReady) begin
            timeout("issue_wait_ready");
        end else begin
            MultiplicandIn = r.a;
            MultiplierIn   = r.b;
            OpCodeIn       = r.opc;
            Funct3In       = r.f3;
            InValid        = 1'b1;
            if (track) begin
                e.res = ref_mul(r.opc, r.f3, r.a, r.b);
                e.acc = cyc;
                e.lat = ref_lat(r.opc, r.f3);
                sb.push_back(e);
            end
            @(negedge Clk);
            InValid = 1'b0;
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!OutValid && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (!OutValid) timeout("wait_out_valid");
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(InReady && sb.size() == 0) && n < 300) begin
            @(negedge Clk);
            n++;
        end
        if (!(InReady && sb.size() == 0)) timeout("wait_idle");
    endtask

    function automatic logic [XLEN-1:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 64'h8000_0000_0000_0000;
            1:       return '1;
            2:       return '0;
            3:       return {32'h0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: the first cycle of each OutValid pulse consumes one expectation.
    // Every later cycle of that pulse must show the same ResultOut.
    always @(negedge Clk) begin
        if (Rst) begin
            seen = 1'b0;
        end else if (OutValid && !seen) begin
            seen = 1'b1;
            held = ResultOut;
            if (sb.size() == 0) begin
                timeout("unexpected_out_valid");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", ResultOut, e.res);
                check("latency", XLEN'(cyc - e.acc), XLEN'(e.lat));
            end
        end else if (OutValid) begin
            check("result_hold", ResultOut, held);
        end
        if (!OutValid) seen = 1'b0;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t dir[8];
        req_t r;
        int   sel;
        bit   stall;

        Rst            = 1'b1;
        Flush          = 1'b0;
        InValid        = 1'b0;
        OutReady       = 1'b1;
        MultiplicandIn = '0;
        MultiplierIn   = '0;
        OpCodeIn       = '0;
        Funct3In       = '0;

        repeat (2) @(negedge Clk);
        check("reset_in_ready", InReady, 1);
        check("reset_out_valid", OutValid, 0);
        check("reset_result", ResultOut, 0);
        Rst = 1'b0;
        @(negedge Clk);

        // Directed cases, including the extremes of signed operands.
        dir[0] = '{OPC_OP, 3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB};
        dir[1] = '{OPC_OP, 3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
        dir[2] = '{OPC_OP, 3'd1, '1, 64'd1};
        dir[3] = '{OPC_OP, 3'd2, '1, '1};
        dir[4] = '{OPC_OP, 3'd3, '1, '1};
        dir[5] = '{OPC_W,  3'd0, 64'h1234_5678_7FFF_FFFF, 64'd2};
        dir[6] = '{OPC_OP, 3'd5, 64'h1234, 64'h5678};
        dir[7] = '{7'b0000011, 3'd0, 64'h1234, 64'h5678};
        foreach (dir[i]) begin
            issue(dir[i], 1'b1);
            wait_idle();
        end

        // Backpressure: DONE holds for 10 cycles, then a release is followed by an immediate new accept.
        OutReady = 1'b0;
        r = '{OPC_OP, 3'd0, 64'h0000_0001_0000_0003, 64'h0000_0000_0000_0007};
        issue(r, 1'b1);
        wait_valid();
        repeat (10) begin
            @(negedge Clk);
            check("bp_in_ready_low", InReady, 0);
        end
        OutReady = 1'b1;
        @(negedge Clk);
        check("bp_release_valid", OutValid, 0);
        check("bp_release_ready", InReady, 1);
        r = '{OPC_OP, 3'd1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0123_4567_89AB_CDEF};
        issue(r, 1'b1);
        check("bp_next_accepted", InReady, 0);
        wait_idle();

        // A flush in the middle of CALC drops the op. Flush also beats InValid in IDLE.
        r = '{OPC_OP, 3'd3, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_0000_0005};
        issue(r, 1'b0);
        repeat (4) @(negedge Clk);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        check("flush_in_ready", InReady, 1);
        check("flush_out_valid", OutValid, 0);
        Flush   = 1'b1;
        InValid = 1'b1;
        @(negedge Clk);
        Flush   = 1'b0;
        InValid = 1'b0;
        check("flush_beats_in_valid", InReady, 1);
        repeat (40) @(negedge Clk);
        check("flush_no_late_valid", OutValid, 0);

        // An asynchronous reset mid-CALC clears the outputs at once. An op issued right after reset is correct.
        r = '{OPC_OP, 3'd2, 64'h8000_0000_0000_0000, '1};
        issue(r, 1'b0);
        repeat (5) @(negedge Clk);
        Rst = 1'b1;
        #1;
        check("rst_out_valid", OutValid, 0);
        check("rst_result", ResultOut, 0);
        check("rst_in_ready", InReady, 1);
        @(negedge Clk);
        Rst = 1'b0;
        r = '{OPC_OP, 3'd1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};
        issue(r, 1'b1);
        wait_idle();

        // Randomized ops, some of them with backpressure stalls.
        repeat (40) begin
            sel = $urandom_range(0, 11);
            if (sel < 8) begin
                r.opc = OPC_OP;
                r.f3  = 3'(sel % 4);
            end else if (sel < 10) begin
                r.opc = OPC_W;
                r.f3  = 3'd0;
            end else if (sel == 10) begin
                r.opc = OPC_OP;
                r.f3  = 3'($urandom_range(4, 7));
            end else begin
                r.opc = OPC_W;
                r.f3  = 3'($urandom_range(1, 7));
            end
            r.a   = rand_opnd();
            r.b   = rand_opnd();
            stall = ($urandom_range(0, 2) == 0);
            if (stall) OutReady = 1'b0;
            issue(r, 1'b1);
            if (stall) begin
                wait_valid();
                repeat ($urandom_range(1, 5)) @(negedge Clk);
                OutReady = 1'b1;
            end
            wait_idle();
        end

        check("scoreboard_drained", XLEN'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_iterative_unit.md
Name: mul_iterative_unit

Overview:
- Parametrised multi-cycle RV64M multiply unit. It replaces the combinational pre/post-processing plus array multiplier in the EX stage.
- Sign preprocessing: operands are converted to magnitudes.
- Iteration: a shift-add multiply retires BITS_PER_CYCLE multiplier bits per cycle.
- Post-processing: the result is conditionally negated, then the low or high half is selected, or the low 32 bits are sign-extended for MULW.
- Talks to EX through a valid/ready handshake on both the input and output sides, and supports a pipeline flush.

Parameters:
XLEN, 64, operand/result width; must be even and a multiple of BITS_PER_CYCLE
BITS_PER_CYCLE, 2, multiplier bits retired per CALC cycle; legal values 1, 2, 4
OPW_EN, 1, when 1 MULW is supported (opcode 7'b0111011); when 0 that opcode returns 0

Ports:
Clk  input  1  clock, rising edge
Rst  input  1  asynchronous active-high reset
Flush  input  1  abort any in-flight op; result discarded
InValid  input  1  request valid
InReady  output  1  unit can accept a request (high only in IDLE)
MultiplicandIn  input  XLEN  rs1
MultiplierIn  input  XLEN  rs2
OpCodeIn  input  7  7'b0110011 (RV32M-class ops) or 7'b0111011 (W ops)
Funct3In  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU (MULW is 000 under 7'b0111011)
OutValid  output  1  result valid
OutReady  input  1  consumer accepts result
ResultOut  output  XLEN  final rd value

Behaviour:
- Clock and reset: one clock, Clk; reset Rst is asynchronous and active-high.
- Reset values: state=IDLE, InReady=1, OutValid=0, ResultOut=0, and all internal accumulator, count and flag registers are 0.
- States:
  - IDLE: InReady=1. On InValid&&!Flush, latch the operands and decode, then go to CALC.
  - CALC: each cycle, add multiplicand*(low BITS_PER_CYCLE bits of the multiplier) into a 2*XLEN accumulator. The multiplier shifts right by BITS_PER_CYCLE and the count decrements. When the count reaches 0, go to DONE.
  - DONE: OutValid=1 and ResultOut is held stable. On OutReady, go to IDLE.
- Latency: handshake in cycle T gives OutValid high from cycle T+N+1.
  - N = XLEN/BITS_PER_CYCLE for non-W ops.
  - N = 32/BITS_PER_CYCLE for MULW, which iterates only over the 32 low bits.
  - With defaults: 33 cycles for 64-bit ops, 17 for MULW.
- Sign preprocessing at accept, with S1 = rs1[XLEN-1] and S2 = rs2[XLEN-1]:
  - MULH: both operands are signed.
  - MULHSU: rs1 is signed, rs2 is unsigned.
  - MUL, MULHU, MULW: both operands are unsigned (the low bits are identical either way).
  - A signed operand whose sign bit is set is replaced by its two's-complement negation. The minimum value -2^(XLEN-1) maps to unsigned 2^(XLEN-1) and must remain correct.
  - NegFlag is registered:
    - MULH: S1^S2
    - MULHSU: S1
    - all other ops: 0
- Post-processing on entry to DONE, with P = unsigned product; if NegFlag, P is replaced by its two's-complement over 2*XLEN bits:
  - MUL: P[XLEN-1:0]
  - MULH/MULHSU/MULHU: P[2XLEN-1:XLEN]
  - MULW: sign-extended P[31:0]
- Unsupported opcode/funct3 combination (including MULW when OPW_EN=0):
  - Accepted normally and runs with N = XLEN/BITS_PER_CYCLE.
  - ResultOut = 0.
- Zero operands: there is no early-out; latency is always N+1, so timing is data-independent.
- Flush:
  - In any state, Flush forces state to IDLE and OutValid to 0 on the next edge. ResultOut is not updated.
  - Flush has priority over InValid in the same cycle, so no accept occurs.
  - Flush in DONE at the same edge as OutReady: the result is dropped and the handshake is not considered complete.
- Backpressure: DONE holds indefinitely while OutReady=0; ResultOut must not change.
- A new request is not accepted in the DONE→IDLE transition cycle (InReady=0 in DONE), so there is one bubble between ops.
- Asynchronous Rst mid-CALC: all outputs return to reset values immediately; no stale OutValid afterwards.

Test Plan:
- MUL rs1=3, rs2=0xFFFF_FFFF_FFFF_FFFB (-5) → ResultOut=0xFFFF_FFFF_FFFF_FFF1; OutValid first seen exactly 33 cycles after the accept cycle.
- MULH rs1=rs2=0x8000_0000_0000_0000 → 0x4000_0000_0000_0000. MULH rs1=-1, rs2=1 → 0xFFFF_FFFF_FFFF_FFFF.
- MULHSU rs1=-1, rs2=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFF. MULHU with the same operands → 0xFFFF_FFFF_FFFF_FFFE.
- MULW (opcode 7'b0111011) rs1=0x1234_5678_7FFF_FFFF, rs2=2 → 0xFFFF_FFFF_FFFF_FFFE after 17 cycles. An unsupported funct3 → 0 after 33 cycles.
- Hold OutReady=0 for 10 cycles in DONE: ResultOut stable and InReady=0. Then OutReady=1 → IDLE next cycle, and a new op is accepted the following cycle.
- Flush at CALC cycle 5 → no OutValid ever for that op, InReady=1 next cycle. Rst pulse mid-CALC → OutValid=0 and ResultOut=0 immediately; a back-to-back op after reset gives the correct result.
